// File: rtl/timer_mc_pkg.sv
// Shared definitions for the multi-channel timer: register indices within a
// channel's four-word window and the CTRL field positions.
package timer_mc_pkg;

    localparam logic [1:0] TMR_CTRL    = 2'd0;
    localparam logic [1:0] TMR_STATUS  = 2'd1;
    localparam logic [1:0] TMR_EXPIRE  = 2'd2;
    localparam logic [1:0] TMR_COUNTER = 2'd3;

    localparam int EN        = 0;
    localparam int PERIODIC  = 1;
    localparam int IRQ_EN    = 2;
    localparam int PRESC_LSB = 8;
    localparam int PRESC_MSB = 15;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: CTRL, EXPIRE, COUNTER, EXPIRED, prescaler and the
// registered interrupt, driven by pre-decoded write strobes.
module timer_channel
    import timer_mc_pkg::*;
#(
    parameter int CNT_W  = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rest,
    input  logic              ctrl_we_i,
    input  logic              status_we_i,
    input  logic              expire_we_i,
    input  logic              counter_we_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic [DATA_W-1:0] ctrl_rd_o,
    output logic [DATA_W-1:0] status_rd_o,
    output logic [DATA_W-1:0] expire_rd_o,
    output logic [DATA_W-1:0] counter_rd_o,
    output logic              irq_o
);

    logic             en_q, en_d, periodic_q, periodic_d, irq_en_q, irq_en_d;
    logic             expired_q, expired_d, irq_q, irq_d;
    logic [7:0]       presc_q, presc_d, pcnt_q, pcnt_d;
    logic [CNT_W-1:0] expire_q, expire_d, count_q, count_d;
    logic             tick_s, hit_s;
    logic             unused_wr_s;

    assign unused_wr_s = ^wr_data_i;

    // Next-state logic; a COUNTER write swallows a coincident tick entirely.
    always_comb begin
        tick_s     = en_q && (pcnt_q == presc_q);
        hit_s      = tick_s && !counter_we_i && (count_q == expire_q);
        en_d       = en_q;
        periodic_d = periodic_q;
        irq_en_d   = irq_en_q;
        presc_d    = presc_q;
        pcnt_d     = pcnt_q;
        expire_d   = expire_q;
        count_d    = count_q;
        expired_d  = expired_q;

        if (ctrl_we_i && wr_data_i[EN]) begin
            pcnt_d = 8'd0;
        end else if (tick_s) begin
            pcnt_d = 8'd0;
        end else if (en_q) begin
            pcnt_d = pcnt_q + 8'd1;
        end else begin
            pcnt_d = pcnt_q;
        end

        if (ctrl_we_i) begin
            en_d       = wr_data_i[EN];
            periodic_d = wr_data_i[PERIODIC];
            irq_en_d   = wr_data_i[IRQ_EN];
            presc_d    = wr_data_i[PRESC_MSB:PRESC_LSB];
        end else if (hit_s && !periodic_q) begin
            en_d = 1'b0;
        end else begin
            en_d = en_q;
        end

        if (expire_we_i) begin
            expire_d = wr_data_i[CNT_W-1:0];
        end else begin
            expire_d = expire_q;
        end

        if (counter_we_i) begin
            count_d = wr_data_i[CNT_W-1:0];
        end else if (hit_s) begin
            count_d = '0;
        end else if (tick_s) begin
            count_d = count_q + CNT_W'(1);
        end else begin
            count_d = count_q;
        end

        if (hit_s) begin
            expired_d = 1'b1;
        end else if (status_we_i && wr_data_i[0]) begin
            expired_d = 1'b0;
        end else begin
            expired_d = expired_q;
        end

        irq_d = expired_d & irq_en_d;
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            en_q       <= 1'b0;
            periodic_q <= 1'b0;
            irq_en_q   <= 1'b0;
            presc_q    <= 8'd0;
            pcnt_q     <= 8'd0;
            expire_q   <= '0;
            count_q    <= '0;
            expired_q  <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            en_q       <= en_d;
            periodic_q <= periodic_d;
            irq_en_q   <= irq_en_d;
            presc_q    <= presc_d;
            pcnt_q     <= pcnt_d;
            expire_q   <= expire_d;
            count_q    <= count_d;
            expired_q  <= expired_d;
            irq_q      <= irq_d;
        end
    end

    // Readback views, zero-extended to the bus width.
    always_comb begin
        ctrl_rd_o                      = '0;
        ctrl_rd_o[EN]                  = en_q;
        ctrl_rd_o[PERIODIC]            = periodic_q;
        ctrl_rd_o[IRQ_EN]              = irq_en_q;
        ctrl_rd_o[PRESC_MSB:PRESC_LSB] = presc_q;
        status_rd_o                    = {{(DATA_W-1){1'b0}}, expired_q};
        expire_rd_o                    = DATA_W'(expire_q);
        counter_rd_o                   = DATA_W'(count_q);
    end

    assign irq_o = irq_q;

endmodule

// File: rtl/timer_mc.sv
// Multi-channel timer bus slave: address decode, per-channel instances,
// registered read mux and one-cycle ready pulse.
module timer_mc
    import timer_mc_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int CNT_W  = 32,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 30
) (
    input  logic              clk,
    input  logic              rest,
    input  logic              Timer_cs,
    input  logic              Timer_as,
    input  logic              Timer_rw,
    input  logic [ADDR_W-1:0] Timer_addr,
    input  logic [DATA_W-1:0] Timer_wr_data,
    output logic [DATA_W-1:0] Timer_rd_data,
    output logic              Timer_rdy,
    output logic [N_CH-1:0]   Timer_irq,
    output logic              Timer_irq_any
);

    logic              access_s, unused_addr_s;
    logic [2:0]        ch_s;
    logic [1:0]        reg_s;
    logic [DATA_W-1:0] rb_s [N_CH][4];
    logic [DATA_W-1:0] rd_mux_s, rd_data_d, rd_data_q;
    logic              rdy_d, rdy_q;
    logic [N_CH-1:0]   irq_s;

    assign access_s      = Timer_cs & Timer_as;
    assign ch_s          = Timer_addr[4:2];
    assign reg_s         = Timer_addr[1:0];
    assign unused_addr_s = ^Timer_addr[ADDR_W-1:5];

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic sel_s;
        assign sel_s = access_s & ~Timer_rw & (ch_s == 3'(c));

        timer_channel #(.CNT_W(CNT_W), .DATA_W(DATA_W)) u_ch (
            .clk          (clk),
            .rest         (rest),
            .ctrl_we_i    (sel_s && (reg_s == TMR_CTRL)),
            .status_we_i  (sel_s && (reg_s == TMR_STATUS)),
            .expire_we_i  (sel_s && (reg_s == TMR_EXPIRE)),
            .counter_we_i (sel_s && (reg_s == TMR_COUNTER)),
            .wr_data_i    (Timer_wr_data),
            .ctrl_rd_o    (rb_s[c][0]),
            .status_rd_o  (rb_s[c][1]),
            .expire_rd_o  (rb_s[c][2]),
            .counter_rd_o (rb_s[c][3]),
            .irq_o        (irq_s[c])
        );
    end

    // Read mux; channel indices with no instance fall through to zero.
    always_comb begin
        rd_mux_s = '0;
        for (int c = 0; c < N_CH; c++) begin
            rd_mux_s = (ch_s == 3'(c)) ? rb_s[c][reg_s] : rd_mux_s;
        end
        rdy_d     = access_s;
        rd_data_d = (access_s && Timer_rw) ? rd_mux_s : '0;
    end

    // Bus response registers.
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            rdy_q     <= 1'b0;
            rd_data_q <= '0;
        end else begin
            rdy_q     <= rdy_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign Timer_rdy     = rdy_q;
    assign Timer_rd_data = rd_data_q;
    assign Timer_irq     = irq_s;
    assign Timer_irq_any = |irq_s;

endmodule

// File: tb/tb_timer_mc.sv
// Self-checking bench for timer_mc (2 channels, 8-bit counters): table of bus
// accesses plus cycle-exact sequences, read data checked via a scoreboard.
module tb_timer_mc;

    localparam int N_CH = 2, CNT_W = 8, DATA_W = 32, ADDR_W = 30;

    logic              clk = 1'b0, rest = 1'b0;
    logic              Timer_cs = 1'b0, Timer_as = 1'b0, Timer_rw = 1'b0;
    logic [ADDR_W-1:0] Timer_addr = '0;
    logic [DATA_W-1:0] Timer_wr_data = '0;
    logic [DATA_W-1:0] Timer_rd_data;
    logic              Timer_rdy, Timer_irq_any;
    logic [N_CH-1:0]   Timer_irq;

    timer_mc #(.N_CH(N_CH), .CNT_W(CNT_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rest(rest), .Timer_cs(Timer_cs), .Timer_as(Timer_as),
        .Timer_rw(Timer_rw), .Timer_addr(Timer_addr), .Timer_wr_data(Timer_wr_data),
        .Timer_rd_data(Timer_rd_data), .Timer_rdy(Timer_rdy),
        .Timer_irq(Timer_irq), .Timer_irq_any(Timer_irq_any)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0, n_fail = 0;

    typedef struct { int due; logic [31:0] data; } sb_t;
    typedef struct { logic rw; logic [29:0] addr; logic [31:0] wdata; logic [31:0] exp; } vec_t;
    sb_t  sb[$];
    vec_t tbl[$];

    function automatic vec_t mk(logic rw, logic [29:0] a, logic [31:0] wd, logic [31:0] e);
        vec_t v;
        v.rw = rw; v.addr = a; v.wdata = wd; v.exp = e;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive one strobed access this cycle; response due one cycle later.
    task automatic acc(input logic rw, input logic [29:0] a, input logic [31:0] wd,
                       input logic [31:0] exp);
        sb_t e;
        @(posedge clk); #1;
        Timer_cs = 1'b1; Timer_as = 1'b1; Timer_rw = rw;
        Timer_addr = a; Timer_wr_data = wd;
        e.due  = cyc + 1;
        e.data = rw ? exp : 32'd0;
        sb.push_back(e);
    endtask

    task automatic idle1();
        @(posedge clk); #1;
        Timer_cs = 1'b0; Timer_as = 1'b0;
    endtask

    // Scoreboard: every ready pulse must match the oldest outstanding access.
    always @(negedge clk) begin
        sb_t  e;
        logic exp_rdy;
        if (rest) begin
            exp_rdy = (sb.size() > 0) && (sb[0].due == cyc);
            if (exp_rdy || Timer_rdy) begin
                n_vec++;
                if (Timer_rdy !== exp_rdy) begin
                    n_fail++;
                    $display("FAIL rdy_timing cyc %0d: got %b expected %b", cyc, Timer_rdy, exp_rdy);
                end
            end
            if (exp_rdy) begin
                e = sb.pop_front();
                n_vec++;
                if (Timer_rd_data !== e.data) begin
                    n_fail++;
                    $display("FAIL rd_data cyc %0d: got %h expected %h", cyc, Timer_rd_data, e.data);
                end
            end
        end
    end

    initial begin
        // ---- reset state and basic register access, back-to-back ----
        for (int r = 0; r < 8; r++) tbl.push_back(mk(1'b1, 30'(r), 32'd0, 32'd0));
        tbl.push_back(mk(1'b0, 30'd4,  32'hFFFF_FFFA, 32'd0));
        tbl.push_back(mk(1'b1, 30'd4,  32'd0, 32'h0000_FF02));
        tbl.push_back(mk(1'b0, 30'd6,  32'h0000_1234, 32'd0));
        tbl.push_back(mk(1'b1, 30'd6,  32'd0, 32'h0000_0034));
        tbl.push_back(mk(1'b0, 30'd7,  32'h0000_ABCD, 32'd0));
        tbl.push_back(mk(1'b1, 30'd7,  32'd0, 32'h0000_00CD));
        tbl.push_back(mk(1'b0, 30'd5,  32'd1, 32'd0));
        tbl.push_back(mk(1'b1, 30'd5,  32'd0, 32'd0));
        tbl.push_back(mk(1'b0, 30'd20, 32'd7, 32'd0));
        tbl.push_back(mk(1'b1, 30'd20, 32'd0, 32'd0));
        tbl.push_back(mk(1'b1, 30'd4,  32'd0, 32'h0000_FF02));
        tbl.push_back(mk(1'b0, 30'd23, 32'h55, 32'd0));
        tbl.push_back(mk(1'b1, 30'd23, 32'd0, 32'd0));
        tbl.push_back(mk(1'b1, 30'd7,  32'd0, 32'h0000_00CD));
        tbl.push_back(mk(1'b1, 30'd38, 32'd0, 32'h0000_0034));
        tbl.push_back(mk(1'b1, 30'h2000_0006, 32'd0, 32'h0000_0034));
        tbl.push_back(mk(1'b0, 30'd4,  32'd0, 32'd0));
        tbl.push_back(mk(1'b1, 30'd4,  32'd0, 32'd0));

        repeat (3) begin
            @(negedge clk);
            chk("reset_rdy", 32'(Timer_rdy), 32'd0);
            chk("reset_rd_data", Timer_rd_data, 32'd0);
            chk("reset_irq", 32'(Timer_irq), 32'd0);
        end
        @(posedge clk); #1 rest = 1'b1;

        foreach (tbl[i]) acc(tbl[i].rw, tbl[i].addr, tbl[i].wdata, tbl[i].exp);
        @(posedge clk); #1;
        Timer_cs = 1'b1; Timer_as = 1'b0; Timer_rw = 1'b1;
        idle1();

        // ---- one-shot with prescaler on ch1: expiry 15 cycles after enable ----
        acc(1'b0, 30'd6, 32'd2, 32'd0);
        acc(1'b0, 30'd7, 32'd0, 32'd0);
        acc(1'b0, 30'd4, 32'h0000_0405, 32'd0);
        repeat (15) idle1();
        @(negedge clk); chk("oneshot_irq_early", 32'(Timer_irq), 32'd0);
        idle1();
        @(negedge clk); chk("oneshot_irq", 32'(Timer_irq), 32'd2);
        chk("oneshot_irq_any", 32'(Timer_irq_any), 32'd1);
        acc(1'b1, 30'd4, 32'd0, 32'h0000_0404);
        acc(1'b1, 30'd7, 32'd0, 32'd0);
        repeat (8) idle1();
        acc(1'b1, 30'd7, 32'd0, 32'd0);
        acc(1'b1, 30'd5, 32'd0, 32'd1);

        // ---- periodic on ch0: 0,1,2,3,0 then irq and clear ----
        acc(1'b0, 30'd2, 32'd3, 32'd0);
        acc(1'b0, 30'd0, 32'd7, 32'd0);
        acc(1'b1, 30'd3, 32'd0, 32'd0);
        acc(1'b1, 30'd3, 32'd0, 32'd1);
        acc(1'b1, 30'd3, 32'd0, 32'd2);
        acc(1'b1, 30'd3, 32'd0, 32'd3);
        @(negedge clk); chk("periodic_irq_pre", 32'(Timer_irq), 32'd2);
        acc(1'b1, 30'd3, 32'd0, 32'd0);
        @(negedge clk); chk("periodic_irq", 32'(Timer_irq), 32'd3);
        acc(1'b0, 30'd1, 32'd1, 32'd0);
        @(negedge clk); chk("periodic_irq_hold", 32'(Timer_irq), 32'd3);
        acc(1'b0, 30'd0, 32'd0, 32'd0);
        @(negedge clk); chk("periodic_irq_clr", 32'(Timer_irq), 32'd2);

        // ---- hardware set beats software clear in the same cycle ----
        acc(1'b0, 30'd3, 32'd0, 32'd0);
        acc(1'b0, 30'd2, 32'd1, 32'd0);
        acc(1'b0, 30'd1, 32'd1, 32'd0);
        acc(1'b0, 30'd0, 32'd3, 32'd0);
        idle1();
        acc(1'b0, 30'd1, 32'd1, 32'd0);
        acc(1'b0, 30'd0, 32'd0, 32'd0);
        acc(1'b1, 30'd1, 32'd0, 32'd1);
        acc(1'b0, 30'd1, 32'd1, 32'd0);
        acc(1'b1, 30'd1, 32'd0, 32'd0);

        // ---- COUNTER write beats tick; 8-bit wrap expiry ----
        acc(1'b0, 30'd2, 32'hFF, 32'd0);
        acc(1'b0, 30'd0, 32'd3, 32'd0);
        acc(1'b0, 30'd3, 32'h10, 32'd0);
        acc(1'b1, 30'd3, 32'd0, 32'h10);
        acc(1'b0, 30'd3, 32'hFE, 32'd0);
        acc(1'b1, 30'd1, 32'd0, 32'd0);
        acc(1'b1, 30'd3, 32'd0, 32'hFF);
        acc(1'b1, 30'd1, 32'd0, 32'd1);
        acc(1'b0, 30'd0, 32'd0, 32'd0);
        acc(1'b1, 30'd3, 32'd0, 32'd2);
        idle1();
        acc(1'b1, 30'd3, 32'd0, 32'd2);
        idle1();

        // ---- reset during a read: no ready, all outputs zero ----
        @(negedge clk); chk("pre_reset_irq_any", 32'(Timer_irq_any), 32'd1);
        acc(1'b1, 30'd4, 32'd0, 32'd0);
        #2;
        rest = 1'b0; Timer_cs = 1'b0; Timer_as = 1'b0;
        sb.delete();
        repeat (2) begin
            @(negedge clk);
            chk("midreset_rdy", 32'(Timer_rdy), 32'd0);
            chk("midreset_rd_data", Timer_rd_data, 32'd0);
            chk("midreset_irq", 32'(Timer_irq), 32'd0);
            chk("midreset_irq_any", 32'(Timer_irq_any), 32'd0);
        end
        @(posedge clk); #1 rest = 1'b1;
        repeat (2) idle1();
        @(negedge clk); chk("post_reset_rdy", 32'(Timer_rdy), 32'd0);
        acc(1'b1, 30'd4, 32'd0, 32'd0);
        acc(1'b1, 30'd7, 32'd0, 32'd0);
        repeat (3) idle1();
        @(negedge clk); chk("sb_drain", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/timer_mc.md
# timer_mc

Parametrised multi-channel timer and bus slave, the successor to the single-channel `Timer` on bus slave slot 0 of `cpu_top`. It provides `N_CH` independent up-counters, each with its own compare value, prescaler, one-shot/periodic mode and maskable interrupt. The single-channel timer had no interrupt support; this block adds it. It connects to the shared slave-side bus signals (`bus_s_addr`, `bus_s_as`, `bus_s_rw`, `bus_s_wr_data`) and its chip-select, and returns read data and ready to the bus mux.

## Interface
- `N_CH`, default 4: number of channels, legal range 1..8.
- `CNT_W`, default 32: counter and compare width, must not exceed `DATA_W`.
- `DATA_W`, default 32: bus data width (`WORD_DATA`).
- `ADDR_W`, default 30: slave address width (`BUS_SLAVE_ADDR`), in words.
- `clk`, input, 1: single clock; all state changes on its rising edge.
- `rest`, input, 1: reset, asynchronous and active-low.
- `Timer_cs`, input, 1: chip select, active-high.
- `Timer_as`, input, 1: address strobe, active-high.
- `Timer_rw`, input, 1: 1 = read, 0 = write.
- `Timer_addr`, input, `ADDR_W`: word address.
- `Timer_wr_data`, input, `DATA_W`: write data.
- `Timer_rd_data`, output, `DATA_W`: read data; 0 whenever `Timer_rdy` is 0.
- `Timer_rdy`, output, 1: one-cycle access-complete pulse.
- `Timer_irq`, output, `N_CH`: per-channel interrupt, driven as `expired & IRQ_EN`.
- `Timer_irq_any`, output, 1: OR of `Timer_irq`.

## Operation
- **Address decode.** `addr[1:0]` selects the register; `addr[4:2]` selects the channel; higher address bits are ignored.
- **Register 0, CTRL (R/W).**
  - bit 0 EN: counter enable.
  - bit 1 PERIODIC: 1 = periodic, 0 = one-shot.
  - bit 2 IRQ_EN: interrupt enable.
  - bits [15:8] PRESC: prescaler reload.
  - All other bits read as 0.
- **Register 1, STATUS.** Bit 0 is EXPIRED. Writing 1 clears it; writing 0 has no effect.
- **Register 2, EXPIRE (R/W).** Compare value, `CNT_W` bits.
- **Register 3, COUNTER (R/W).** Current count, `CNT_W` bits.
- **Width rules.** Reads zero-extend to `DATA_W`; writes keep the low `CNT_W` bits.
- **Out-of-range channel** (index ≥ `N_CH`): reads return 0, writes are ignored, and `Timer_rdy` still pulses.
- **Tick.** While EN=1, the prescaler counts 0..PRESC and emits a tick when it reaches PRESC, then returns to 0. This gives one tick every PRESC+1 cycles. While EN=0, both the prescaler and COUNTER hold their values.
- **Counting on a tick.**
  - If COUNTER == EXPIRE: set EXPIRED and load COUNTER with 0. If PERIODIC=0, also clear EN.
  - Otherwise: COUNTER ← COUNTER + 1, wrapping modulo 2^CNT_W.
  - EXPIRE = 0 with PERIODIC=1 therefore fires on every tick.
- **Prescaler restart.** Any CTRL write with EN=1 resets the prescaler to 0.
- **Simultaneous events.**
  - A hardware EXPIRED set and a software clear in the same cycle: the set wins.
  - A COUNTER write and a tick in the same cycle: the write wins and the tick is discarded.
  - A CTRL write and a one-shot auto-clear of EN in the same cycle: the written value wins.
- **Reset.** All registers reset to 0; all channels come up disabled with no interrupt.

## Timing
- **Access start.** An access begins on a cycle where `Timer_cs & Timer_as` = 1.
- **Write.** Register state updates at that cycle's edge. `Timer_rdy` = 1 on the following cycle.
- **Read.** `Timer_rd_data` is registered and valid with `Timer_rdy` = 1 on the following cycle. Read latency is 1.
- **Back-to-back accesses.** Consecutive strobed cycles are accepted every cycle. Each produces a `Timer_rdy` pulse one cycle later.
- **Interrupt.** `Timer_irq[c]` rises the cycle after the tick that matched. It falls the cycle after the STATUS write-1-clear or the IRQ_EN clear.
- **Outputs under reset.** While `rest` = 0: `Timer_rdy` = 0, `Timer_rd_data` = 0, `Timer_irq` = 0, `Timer_irq_any` = 0.
- **Reset mid-access.** An access in flight is dropped, and no `Timer_rdy` pulse is produced.

## Structure
- **Shared package** (alongside `global.v`): register index constants `TMR_CTRL`, `TMR_STATUS`, `TMR_EXPIRE`, `TMR_COUNTER`, and the CTRL bit positions `EN`, `PERIODIC`, `IRQ_EN`, `PRESC_LSB`, `PRESC_MSB`.
- **Sub-module `timer_channel`** holds one channel: CTRL, EXPIRE, COUNTER, EXPIRED, the prescaler and the irq logic. It takes decoded per-channel write strobes and exposes its registers for readback.
- **Top.** `timer_mc` generates `N_CH` instances of `timer_channel` and contains the address decode, the read mux and the `Timer_rdy` register.

## Test plan
- **Reset.** Hold `rest` = 0 and read every register after release → all reads return 0, `Timer_irq` = 0, and each `Timer_rdy` pulse comes exactly 1 cycle after its strobe.
- **Periodic.** Ch0: EXPIRE=3, CTRL=EN\|PERIODIC\|IRQ_EN, PRESC=0 → COUNTER sequence 0,1,2,3,0. `Timer_irq[0]` rises the cycle after the 3→0 transition. Writing STATUS=1 clears it the next cycle.
- **One-shot with prescaler.** Ch1: EXPIRE=2, PRESC=4, one-shot → first expiry 15 cycles after enable. EN then reads 0 and COUNTER holds at 0.
- **Set versus clear.** Drive a STATUS write-1-clear on the same cycle as a match → EXPIRED stays 1.
- **Write versus tick.** Write COUNTER=0x10 on a tick cycle → reads back 0x10, not 0x11. With CNT_W=8 and EXPIRE=0xFF, COUNTER=0xFE leads to expiry after 2 ticks.
- **Out-of-range channel.** With `N_CH`=2, access channel 5 → read returns 0, the write has no effect, and `Timer_rdy` still pulses. Assert `rest` mid-read → no `Timer_rdy` pulse and all outputs are 0.
